// File: rtl/baud_pkg.sv
// Shared defaults and a divisor helper for the fractional baud generator.
package baud_pkg;

  localparam int unsigned BAUD_DIV_INT_W  = 16;
  localparam int unsigned BAUD_DIV_FRAC_W = 4;
  localparam int unsigned BAUD_OVERSAMPLE = 16;

  typedef struct packed {
    logic [31:0] div_int;
    logic [31:0] div_frac;
  } baud_div_t;

  // Rounded fixed-point clk_freq / (baud_rate * oversample) with frac_w fraction bits.
  function automatic baud_div_t baud_calc_div(input longint unsigned clk_freq,
                                              input longint unsigned baud_rate,
                                              input longint unsigned oversample,
                                              input int unsigned     frac_w);
    longint unsigned denom;
    longint unsigned fixed;
    baud_div_t       d;
    denom      = baud_rate * oversample;
    fixed      = ((clk_freq << frac_w) + denom / 2) / denom;
    d.div_int  = 32'(fixed >> frac_w);
    d.div_frac = 32'(fixed & ((64'd1 << frac_w) - 64'd1));
    return d;
  endfunction

endpackage

// File: rtl/baud_gen_frac.sv
// Fractional-N baud generator: os_tick every div_int(+1) cycles, bit_tick every
// OVERSAMPLE os_ticks, with shadowed divisor updates applied at period boundaries.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int unsigned DIV_INT_W        = BAUD_DIV_INT_W,
  parameter int unsigned DIV_FRAC_W       = BAUD_DIV_FRAC_W,
  parameter int unsigned OVERSAMPLE       = BAUD_OVERSAMPLE,
  parameter int unsigned DEFAULT_DIV_INT  = 54,
  parameter int unsigned DEFAULT_DIV_FRAC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  div_load,
  input  logic [DIV_INT_W-1:0]  div_int,
  input  logic [DIV_FRAC_W-1:0] div_frac,
  output logic                  os_tick,
  output logic                  bit_tick,
  output logic                  cfg_err
);

  localparam int unsigned OSW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  logic [DIV_INT_W-1:0]  act_int, sh_int, eff_int;
  logic [DIV_FRAC_W-1:0] act_frac, sh_frac, eff_frac, frac_acc;
  logic [DIV_FRAC_W:0]   frac_sum;
  logic [DIV_INT_W:0]    cnt, cnt_inc, plen;
  logic [OSW-1:0]        os_cnt, os_next;
  logic                  pending, act_bad, eff_bad, start, apply, os_last, last_cyc;

  always_comb begin
    act_bad  = act_int < DIV_INT_W'(2);
    // cnt==0 means idle; os_tick high marks the edge that ends a period
    start    = en && !act_bad && ((cnt == '0) || os_tick);
    apply    = pending && (start || !en || act_bad);
    eff_int  = apply ? sh_int  : act_int;
    eff_frac = apply ? sh_frac : act_frac;
    eff_bad  = eff_int < DIV_INT_W'(2);
    frac_sum = {1'b0, frac_acc} + {1'b0, eff_frac};
    cnt_inc  = cnt + 1'b1;
    last_cyc = cnt_inc == plen;
    os_last  = os_cnt == OSW'(OVERSAMPLE - 1);
    os_next  = os_last ? '0 : os_cnt + 1'b1;
  end

  assign cfg_err = act_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      act_int  <= DIV_INT_W'(DEFAULT_DIV_INT);
      act_frac <= DIV_FRAC_W'(DEFAULT_DIV_FRAC);
      sh_int   <= DIV_INT_W'(DEFAULT_DIV_INT);
      sh_frac  <= DIV_FRAC_W'(DEFAULT_DIV_FRAC);
      pending  <= 1'b0;
      frac_acc <= '0;
      cnt      <= '0;
      plen     <= '0;
      os_cnt   <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      if (div_load) begin
        sh_int  <= div_int;
        sh_frac <= div_frac;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end

      if (apply) begin
        act_int  <= sh_int;
        act_frac <= sh_frac;
      end

      if (!en || act_bad || (start && eff_bad)) begin
        frac_acc <= '0;
        cnt      <= '0;
        plen     <= '0;
        os_cnt   <= '0;
        os_tick  <= 1'b0;
        bit_tick <= 1'b0;
      end else if (start) begin
        frac_acc <= frac_sum[DIV_FRAC_W-1:0];
        plen     <= {1'b0, eff_int} + {{DIV_INT_W{1'b0}}, frac_sum[DIV_FRAC_W]};
        cnt      <= (DIV_INT_W + 1)'(1);
        os_tick  <= 1'b0;
        bit_tick <= 1'b0;
        if (os_tick) os_cnt <= os_next;
      end else begin
        cnt      <= cnt_inc;
        os_tick  <= last_cyc;
        bit_tick <= last_cyc && os_last;
      end
    end
  end

endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DIV_INT_W, 16, integer divisor width.
- DIV_FRAC_W, 4, fractional divisor width; fraction step is 1/2^DIV_FRAC_W.
- OVERSAMPLE, 16, os_tick count per bit_tick.
- DEFAULT_DIV_INT, 54, divisor integer part after reset.
- DEFAULT_DIV_FRAC, 4, divisor fractional part after reset.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- rst, in, 1, reset, synchronous, active-high.
- en, in, 1, generator enable.
- div_load, in, 1, one-cycle strobe that captures div_int/div_frac.
- div_int, in, DIV_INT_W, integer divisor in clk cycles.
- div_frac, in, DIV_FRAC_W, fractional divisor numerator.
- os_tick, out, 1, one-cycle oversample tick.
- bit_tick, out, 1, one-cycle bit-rate tick.
- cfg_err, out, 1, active divisor is invalid (div_int < 2).
REQ-003 The design SHALL use one clock, clk; reset SHALL be synchronous and active-high on rst.

Function
REQ-004 The average os_tick period SHALL be div_int + div_frac/2^DIV_FRAC_W clk cycles.
REQ-005 At each period start, frac_acc (DIV_FRAC_W bits) SHALL take the value frac_acc + div_frac modulo 2^DIV_FRAC_W. That period SHALL last div_int+1 cycles if the addition carried out, otherwise div_int cycles.
REQ-006 os_tick SHALL be registered and high for exactly one cycle, in the last cycle of each period.
REQ-007 An os counter (0..OVERSAMPLE-1) SHALL advance on each os_tick and wrap to 0. bit_tick SHALL be high in the same cycle as the os_tick on which that counter wraps.
REQ-008 While en=0, the period counter, frac_acc and os counter SHALL be held at 0, and os_tick and bit_tick SHALL be 0.
REQ-009 The first period SHALL start on the first edge that samples en=1. The first os_tick SHALL be in the div_int-th cycle after that edge.
REQ-010 On a div_load edge, div_int and div_frac SHALL be captured into shadow registers.
REQ-011 The active divisor SHALL take the shadow value at the first period start strictly after the load edge. When en=0, it SHALL take the shadow value on the next edge.
REQ-012 If div_load coincides with a period-start edge, the old active divisor SHALL govern the period that is starting.
REQ-013 A second div_load before the update is applied SHALL overwrite the shadow registers; the last value wins.
REQ-014 A div_load while en=0 SHALL NOT reset frac_acc.
REQ-015 If the active div_int < 2, cfg_err SHALL be 1, both ticks SHALL be 0, and the counters SHALL be held at 0.
REQ-016 cfg_err SHALL clear when a valid divisor becomes active.
REQ-017 Counter widths SHALL hold div_int+1 without overflow at the maximum div_int.

Reset
REQ-018 When rst=1 on an edge, the following SHALL take effect:
- os_tick=0, bit_tick=0.
- period counter, os counter and frac_acc = 0.
- active and shadow divisors = DEFAULT_DIV_INT / DEFAULT_DIV_FRAC.
- cfg_err = (DEFAULT_DIV_INT < 2).
REQ-019 rst SHALL take priority over en and div_load, including in the middle of a period. The first os_tick after reset release with en=1 SHALL follow REQ-009.

Structure
REQ-020 A package baud_pkg SHALL hold:
- the default widths and the OVERSAMPLE default;
- a constant function that computes the integer and fractional divisor from CLK_FREQ, BAUD_RATE and OVERSAMPLE, for use in parameter defaults.
REQ-021 The design SHALL be a single module with no sub-module. The fractional accumulator SHALL be inline logic.

Verification
REQ-022 Scenario: div_int=4, div_frac=0, OVERSAMPLE=16, en=1 -> os_tick every 4 cycles; bit_tick every 64 cycles, coincident with every 16th os_tick.
REQ-023 Scenario: div_int=4, div_frac=8, DIV_FRAC_W=4 -> periods 4,5,4,5,...; exactly 16 os_ticks in 72 cycles.
REQ-024 Scenario: div_load of div_int=10 two cycles into a div_int=6 period -> current period completes at 6; the following period is 10.
REQ-025 Scenario: div_load of div_int=1 -> after the update applies, cfg_err=1 and no ticks; a div_load of div_int=3 -> cfg_err=0 and os_tick every 3 cycles.
REQ-026 Scenario: en dropped mid-period, then raised -> ticks stop immediately; the first os_tick comes div_int cycles after re-enable.
REQ-027 Scenario: rst pulsed mid-period -> next-cycle outputs 0; defaults 54/4 active; tick timing restarts from 0.
